alu_unit: RTL and testbench



---
 rtl/alu_unit.sv | 180 ++++++++++++++++++
 tb/tb_alu_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: sequential ALU between the control FSM and the AC register.
// Add, subtract and left shift finish in one cycle. Multiply is an iterative
// shift-add that takes WIDTH cycles. Build option: define ALU_MULT_EN to
// include the multiplier; without it, opcode 3 is reported as illegal.
module alu_unit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] ac_in,
   input  logic [WIDTH-1:0] r_in,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             z,
   output logic             ovf,
   output logic             busy,
   output logic             illegal_op
);

   typedef enum logic [2:0] {
      OP_NONE   = 3'd0,
      OP_ADD    = 3'd1,
      OP_SUB    = 3'd2,
      OP_MULT   = 3'd3,
      OP_LSHIFT = 3'd4
   } alu_op_e;

   logic [WIDTH-1:0]   r_result;
   logic               r_valid;
   logic               r_z;
   logic               r_ovf;
   logic               r_illegal;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_shl;
   logic [WIDTH-1:0]   w_res;
   logic               w_ovf;
   logic               w_single;
   logic               w_idle;
   logic               w_illegal;

`ifdef ALU_MULT_EN
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   state_e             r_state;
   state_e             w_state_next;
   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   r_mplier;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_mul_done;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Next state plus the arithmetic of one shift-add step
   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
      w_cnt_next   = r_cnt + CNT_W'(1);
      w_mul_done   = 1'b0;
      case (r_state)
         ST_IDLE: if (alu_op == OP_MULT) w_state_next = ST_MUL;
         ST_MUL: begin
            if (w_cnt_next == CNT_W'(WIDTH)) begin
               w_mul_done   = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Multiplier operand capture and iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == ST_IDLE) begin
         if (alu_op == OP_MULT) begin
            r_mcand  <= {{WIDTH{1'b0}}, ac_in};
            r_mplier <= r_in;
            r_acc    <= '0;
            r_cnt    <= '0;
         end
      end else begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= w_cnt_next;
      end
   end

   assign w_idle    = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_MUL);
   assign w_illegal = w_idle && (alu_op > OP_LSHIFT);
`else
   assign w_idle    = 1'b1;
   assign busy      = 1'b0;
   assign w_illegal = w_idle && ((alu_op > OP_LSHIFT) || (alu_op == OP_MULT));
`endif

   // Single-cycle operation results and their overflow conditions
   always_comb begin
      w_sum    = {1'b0, ac_in} + {1'b0, r_in};
      w_diff   = {1'b0, ac_in} - {1'b0, r_in};
      w_shl    = {{WIDTH{1'b0}}, ac_in} << r_in[3:0];
      w_res    = '0;
      w_ovf    = 1'b0;
      w_single = 1'b0;
      if (w_idle) begin
         case (alu_op)
            OP_ADD: begin
               w_res    = w_sum[WIDTH-1:0];
               w_ovf    = w_sum[WIDTH];
               w_single = 1'b1;
            end
            OP_SUB: begin
               w_res    = w_diff[WIDTH-1:0];
               w_ovf    = w_diff[WIDTH];
               w_single = 1'b1;
            end
            OP_LSHIFT: begin
               w_res    = w_shl[WIDTH-1:0];
               w_ovf    = |w_shl[2*WIDTH-1:WIDTH];
               w_single = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Result, flags, completion pulse and sticky illegal-op register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_result  <= '0;
         r_valid   <= 1'b0;
         r_z       <= 1'b1;
         r_ovf     <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_illegal) r_illegal <= 1'b1;
         if (w_single) begin
            r_result <= w_res;
            r_z      <= (w_res == '0);
            r_ovf    <= w_ovf;
            r_valid  <= 1'b1;
         end
`ifdef ALU_MULT_EN
         else if (w_mul_done) begin
            r_result <= w_acc_next[WIDTH-1:0];
            r_z      <= (w_acc_next[WIDTH-1:0] == '0);
            r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_valid  <= 1'b1;
         end
`endif
      end
   end

   assign result       = r_result;
   assign result_valid = r_valid;
   assign z            = r_z;
   assign ovf          = r_ovf;
   assign illegal_op   = r_illegal;

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors with hand-computed results for alu_unit.
// Multiplier tests run when ALU_MULT_EN is defined; otherwise opcode 3 is
// checked as an illegal op.
module tb_alu_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  alu_op;
   logic [15:0] ac_in;
   logic [15:0] r_in;
   logic [15:0] result;
   logic        result_valid;
   logic        z;
   logic        ovf;
   logic        busy;
   logic        illegal_op;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_unit #(.WIDTH(16), .CNT_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_op       (alu_op),
      .ac_in        (ac_in),
      .r_in         (r_in),
      .result       (result),
      .result_valid (result_valid),
      .z            (z),
      .ovf          (ovf),
      .busy         (busy),
      .illegal_op   (illegal_op)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive an op for one sampling edge; returns at the negedge after it
   task automatic apply(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      alu_op = op;
      ac_in  = a;
      r_in   = b;
      @(negedge clk);
      alu_op = 3'd0;
   endtask

   // Check a single-cycle completion, then that the pulse lasts one cycle
   task automatic check_single(input string tag, input logic [15:0] res,
                               input logic zz, input logic oo);
      check({tag, "_valid"}, result_valid, 1);
      check({tag, "_result"}, result, res);
      check({tag, "_z"}, z, zz);
      check({tag, "_ovf"}, ovf, oo);
      @(negedge clk);
      check({tag, "_pulse"}, result_valid, 0);
      check({tag, "_hold"}, result, res);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

`ifdef ALU_MULT_EN
   // Multiply with alu_op=ADD and operand changes held during the first iterations
   task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic oo, input logic zz,
                           input logic [15:0] prev);
      int vk = 0;
      int nv = 0;
      int bc = 0;
      logic [15:0] got_res = '0;
      logic got_ovf = 1'b0;
      logic got_z = 1'b0;
      @(negedge clk);
      alu_op = 3'd3;
      ac_in  = a;
      r_in   = b;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (busy) bc++;
         if (result_valid) begin
            nv++;
            if (vk == 0) begin
               vk      = k;
               got_res = result;
               got_ovf = ovf;
               got_z   = z;
            end
         end
         if (k == 5) check({tag, "_mid_hold"}, result, prev);
         if (k <= 8) begin
            alu_op = 3'd1;
            ac_in  = 16'h0101;
            r_in   = 16'h0202;
         end else begin
            alu_op = 3'd0;
         end
      end
      check({tag, "_latency"}, vk, 17);
      check({tag, "_pulses"}, nv, 1);
      check({tag, "_busy_cycles"}, bc, 16);
      check({tag, "_result"}, got_res, res);
      check({tag, "_ovf"}, got_ovf, oo);
      check({tag, "_z"}, got_z, zz);
   endtask
`endif

   initial begin
      rst    = 1'b1;
      alu_op = 3'd0;
      ac_in  = '0;
      r_in   = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      check("rst_result", result, 16'h0000);
      check("rst_valid", result_valid, 0);
      check("rst_z", z, 1);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_illegal", illegal_op, 0);

      apply(3'd1, 16'hFFFF, 16'h0001);
      check_single("add_wrap", 16'h0000, 1'b1, 1'b1);

      apply(3'd2, 16'd5, 16'd5);
      check_single("sub_eq", 16'h0000, 1'b1, 1'b0);

      apply(3'd4, 16'h0003, 16'd4);
      check_single("shl", 16'h0030, 1'b0, 1'b0);

      apply(3'd4, 16'h8001, 16'd1);
      check_single("shl_ovf", 16'h0002, 1'b0, 1'b1);

      apply(3'd2, 16'd3, 16'd5);
      check_single("sub_borrow", 16'hFFFE, 1'b0, 1'b1);

      // Back-to-back ops on consecutive edges
      @(negedge clk);
      alu_op = 3'd1;
      ac_in  = 16'h1234;
      r_in   = 16'h0001;
      @(negedge clk);
      check("b2b_add_result", result, 16'h1235);
      check("b2b_add_valid", result_valid, 1);
      alu_op = 3'd4;
      ac_in  = 16'h00F0;
      r_in   = 16'h0014;   // only B[3:0]=4 is used
      @(negedge clk);
      alu_op = 3'd0;
      check_single("b2b_shl", 16'h0F00, 1'b0, 1'b0);

`ifdef ALU_MULT_EN
      run_mult("mul_300x200", 16'd300, 16'd200, 16'hEA60, 1'b0, 1'b0, 16'h0F00);
      run_mult("mul_300x300", 16'd300, 16'd300, 16'h5F90, 1'b1, 1'b0, 16'hEA60);

      // Abort a multiply with reset after iteration 8
      begin
         int nv = 0;
         @(negedge clk);
         alu_op = 3'd3;
         ac_in  = 16'd300;
         r_in   = 16'd300;
         @(negedge clk);
         alu_op = 3'd0;
         repeat (7) @(negedge clk);
         check("abort_busy_before", busy, 1);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check("abort_busy", busy, 0);
         check("abort_result", result, 16'h0000);
         check("abort_z", z, 1);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (result_valid) nv++;
         end
         check("abort_no_valid", nv, 0);
         check("abort_busy_after", busy, 0);
      end
`else
      begin
         int bc = 0;
         apply(3'd3, 16'd300, 16'd200);
         check("mul_off_illegal", illegal_op, 1);
         check("mul_off_valid", result_valid, 0);
         check("mul_off_result", result, 16'h0F00);
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (result_valid) bc++;
         end
         check("mul_off_quiet", bc, 0);
         do_reset();
         check("mul_off_rst_illegal", illegal_op, 0);
      end
`endif

      apply(3'd6, 16'd1, 16'd2);
      check("ill_flag", illegal_op, 1);
      check("ill_valid", result_valid, 0);
      check("ill_result", result, 16'h0000);
      check("ill_z", z, 1);
      check("ill_ovf", ovf, 0);
      repeat (3) @(negedge clk);
      check("ill_sticky", illegal_op, 1);

      apply(3'd1, 16'd2, 16'd3);
      check_single("add_after_ill", 16'h0005, 1'b0, 1'b0);
      check("ill_still_set", illegal_op, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
